// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for alu_op_sequencer.
// master = control unit side, slave = sequencer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_neg;
    logic             rsp_ovf;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result,
        input  rsp_neg, rsp_ovf, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result,
        output rsp_neg, rsp_ovf, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: accept request, load operands, execute,
// capture result/flags and return them on the response handshake.
// Ports: clk, reset_n (async active-low), bus (request/response, slave),
//   alu_A/alu_B/A_write/B_write/ALUout_write/ALUop/Func to the ALU,
//   Result/isNegative/overflow/isZero from the ALU, op_count of responses.
module alu_op_sequencer #(
    parameter int WIDTH     = 16,
    parameter int EXEC_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             A_write,
    output logic             B_write,
    output logic             ALUout_write,
    output logic [1:0]       ALUop,
    output logic [3:0]       Func,
    input  logic [WIDTH-1:0] Result,
    input  logic             isNegative,
    input  logic             overflow,
    input  logic             isZero,
    output logic [15:0]      op_count
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        CAPT,
        RESP
    } state_t;

    state_t     state;
    logic [1:0] wait_cnt;

    logic       legal;
    logic [1:0] dec_op;
    logic [3:0] dec_fn;

    // Opcodes 8..15 are R-type with the function in the low three bits.
    always_comb begin
        legal  = 1'b1;
        dec_op = 2'd0;
        dec_fn = 4'd0;
        unique case (1'b1)
            bus.req_op[3]: begin
                dec_op = 2'd2;
                dec_fn = {1'b0, bus.req_op[2:0]};
            end
            bus.req_op == 4'd0: dec_op = 2'd0;
            bus.req_op == 4'd1: dec_op = 2'd1;
            bus.req_op == 4'd2: dec_op = 2'd3;
            default:            legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_cnt       <= 2'd0;
            alu_A          <= '0;
            alu_B          <= '0;
            A_write        <= 1'b0;
            B_write        <= 1'b0;
            ALUout_write   <= 1'b0;
            ALUop          <= 2'd0;
            Func           <= 4'd0;
            op_count       <= 16'd0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_neg    <= 1'b0;
            bus.rsp_ovf    <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (legal) begin
                            alu_A   <= bus.req_a;
                            alu_B   <= bus.req_b;
                            A_write <= 1'b1;
                            B_write <= 1'b1;
                            ALUop   <= dec_op;
                            Func    <= dec_fn;
                            state   <= LOAD;
                        end else begin
                            // Illegal op skips the ALU entirely.
                            bus.rsp_result <= '0;
                            bus.rsp_neg    <= 1'b0;
                            bus.rsp_ovf    <= 1'b0;
                            bus.rsp_zero   <= 1'b0;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_valid  <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                LOAD: begin
                    A_write      <= 1'b0;
                    B_write      <= 1'b0;
                    ALUout_write <= 1'b1;
                    wait_cnt     <= 2'(EXEC_WAIT);
                    state        <= EXEC;
                end
                EXEC: begin
                    ALUout_write <= 1'b0;
                    if (wait_cnt == 2'd0) begin
                        state <= CAPT;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                CAPT: begin
                    bus.rsp_result <= Result;
                    bus.rsp_neg    <= isNegative;
                    bus.rsp_ovf    <= overflow;
                    bus.rsp_zero   <= isZero;
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid  <= 1'b0;
                        bus.rsp_result <= '0;
                        bus.rsp_neg    <= 1'b0;
                        bus.rsp_ovf    <= 1'b0;
                        bus.rsp_zero   <= 1'b0;
                        bus.rsp_err    <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        alu_A          <= '0;
                        alu_B          <= '0;
                        ALUop          <= 2'd0;
                        Func           <= 4'd0;
                        op_count       <= op_count + 16'd1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
